// File: rtl/rvc_expander.sv
// RV64C decompressor: rewrites 16-bit compressed fetch words into 32-bit RV64I.
// Also latches the PC of the last illegal compressed encoding for debug.
module rvc_expander (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] inst_o,
  output logic        illegal_o,
  output logic [63:0] illegal_pc_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_REG32 = 7'b0111011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [4:0] X0 = 5'd0;
  localparam logic [4:0] RA = 5'd1;
  localparam logic [4:0] SP = 5'd2;

  function automatic logic [31:0] i_type(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_type(
    input logic [11:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] r_type(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [5:0]  imm6;
  logic [11:0] imm6s;
  logic [6:0]  lw_off;
  logic [7:0]  ld_off;
  logic [9:0]  a4_imm;
  logic [9:0]  a16_imm;
  logic [7:0]  lwsp_off;
  logic [8:0]  ldsp_off;
  logic [7:0]  swsp_off;
  logic [8:0]  sdsp_off;
  logic [31:0] exp;
  logic        ill;

  assign c        = inst_i[15:0];
  assign rd       = c[11:7];
  assign rs2      = c[6:2];
  assign rdp      = {2'b01, c[4:2]};
  assign rs1p     = {2'b01, c[9:7]};
  assign imm6     = {c[12], c[6:2]};
  assign imm6s    = {{6{c[12]}}, imm6};
  assign lw_off   = {c[5], c[12:10], c[6], 2'b00};
  assign ld_off   = {c[6:5], c[12:10], 3'b000};
  assign a4_imm   = {c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign a16_imm  = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
  assign lwsp_off = {c[3:2], c[12], c[6:4], 2'b00};
  assign ldsp_off = {c[4:2], c[12], c[6:5], 3'b000};
  assign swsp_off = {c[8:7], c[12:9], 2'b00};
  assign sdsp_off = {c[9:7], c[12:10], 3'b000};

  always_comb begin
    exp = '0;
    ill = 1'b0;
    if (inst_i[1:0] == 2'b11) begin
      exp = inst_i;
    end else begin
      case ({c[1:0], c[15:13]})
        5'b00_000: begin
          exp = i_type({2'b00, a4_imm}, SP, 3'b000, rdp, OP_IMM);
          ill = (a4_imm == '0);
        end
        5'b00_010: exp = i_type({5'b0, lw_off}, rs1p, 3'b010, rdp, OP_LOAD);
        5'b00_011: exp = i_type({4'b0, ld_off}, rs1p, 3'b011, rdp, OP_LOAD);
        5'b00_110: exp = s_type({5'b0, lw_off}, rdp, rs1p, 3'b010);
        5'b00_111: exp = s_type({4'b0, ld_off}, rdp, rs1p, 3'b011);
        5'b01_000: exp = i_type(imm6s, rd, 3'b000, rd, OP_IMM);
        5'b01_001: begin
          exp = i_type(imm6s, rd, 3'b000, rd, OP_IMM32);
          ill = (rd == X0);
        end
        5'b01_010: exp = i_type(imm6s, X0, 3'b000, rd, OP_IMM);
        5'b01_011: begin
          if (rd == SP) begin
            exp = i_type({{2{c[12]}}, a16_imm}, SP, 3'b000, SP, OP_IMM);
            ill = (a16_imm == '0);
          end else begin
            exp = {{14{c[12]}}, imm6, rd, OP_LUI};
            ill = (imm6 == '0);
          end
        end
        5'b01_100: begin
          unique case (c[11:10])
            2'b00: exp = i_type({6'b000000, imm6}, rs1p, 3'b101, rs1p, OP_IMM);
            2'b01: exp = i_type({6'b010000, imm6}, rs1p, 3'b101, rs1p, OP_IMM);
            2'b10: exp = i_type(imm6s, rs1p, 3'b111, rs1p, OP_IMM);
            2'b11: begin
              // c[12] selects the 32-bit word ops; only SUBW/ADDW exist there
              unique case ({c[12], c[6:5]})
                3'b000: exp = r_type(7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG);
                3'b001: exp = r_type(7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG);
                3'b010: exp = r_type(7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG);
                3'b011: exp = r_type(7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG);
                3'b100: exp = r_type(7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG32);
                3'b101: exp = r_type(7'b0000000, rdp, rs1p, 3'b000, rs1p, OP_REG32);
                default: ill = 1'b1;
              endcase
            end
          endcase
        end
        5'b01_101:
          exp = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11],
                 c[5:3], c[12], {8{c[12]}}, X0, OP_JAL};
        5'b01_110, 5'b01_111:
          exp = {c[12], {3{c[12]}}, c[6:5], c[2], X0, rs1p,
                 {2'b00, c[13]}, c[11:10], c[4:3], c[12], OP_BR};
        5'b10_000: exp = i_type({6'b0, imm6}, rd, 3'b001, rd, OP_IMM);
        5'b10_010: begin
          exp = i_type({4'b0, lwsp_off}, SP, 3'b010, rd, OP_LOAD);
          ill = (rd == X0);
        end
        5'b10_011: begin
          exp = i_type({3'b0, ldsp_off}, SP, 3'b011, rd, OP_LOAD);
          ill = (rd == X0);
        end
        5'b10_100: begin
          unique case (1'b1)
            !c[12] && rs2 == X0: begin
              exp = i_type(12'h000, rd, 3'b000, X0, OP_JALR);
              ill = (rd == X0);
            end
            !c[12] && rs2 != X0:
              exp = r_type(7'b0, rs2, X0, 3'b000, rd, OP_REG);
            c[12] && rd == X0 && rs2 == X0:
              exp = 32'h0010_0073;
            c[12] && rd != X0 && rs2 == X0:
              exp = i_type(12'h000, rd, 3'b000, RA, OP_JALR);
            c[12] && rs2 != X0:
              exp = r_type(7'b0, rs2, rd, 3'b000, rd, OP_REG);
          endcase
        end
        5'b10_110: exp = s_type({4'b0, swsp_off}, rs2, SP, 3'b010);
        5'b10_111: exp = s_type({3'b0, sdsp_off}, rs2, SP, 3'b011);
        default:   ill = 1'b1;
      endcase
    end
  end

  assign inst_o    = ill ? 32'h0000_0000 : exp;
  assign illegal_o = ill;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      illegal_pc_o <= '0;
    else if (illegal_o)
      illegal_pc_o <= pc_i;
  end

endmodule

// File: tb/tb_rvc_expander.sv
// Directed bench for rvc_expander: hand-encoded RVC vectors and the
// illegal-PC debug register.
module tb_rvc_expander;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] pc_i = '0;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_o;
  logic        illegal_o;
  logic [63:0] illegal_pc_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  rvc_expander dut (
    .clock        (clock),
    .reset        (reset),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .inst_o       (inst_o),
    .illegal_o    (illegal_o),
    .illegal_pc_o (illegal_pc_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic vec(input string tag, input logic [31:0] in,
                     input logic [31:0] exp, input logic ill);
    inst_i = in;
    #1;
    chk({tag, ".inst"}, {32'b0, inst_o}, {32'b0, exp});
    chk({tag, ".ill"}, {63'b0, illegal_o}, {63'b0, ill});
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 chk("reset_pc", illegal_pc_o, 64'h0);
    reset = 1'b0;

    vec("pass32",    32'h00A0_0513, 32'h00A0_0513, 1'b0);
    vec("addi4spn",  32'h0000_0040, 32'h0041_0413, 1'b0);
    vec("li",        32'h0000_4515, 32'h0050_0513, 1'b0);
    vec("mv",        32'h0000_852E, 32'h00B0_0533, 1'b0);
    vec("jr",        32'h0000_8082, 32'h0000_8067, 1'b0);
    vec("ebreak",    32'h0000_9002, 32'h0010_0073, 1'b0);
    vec("upper_ign", 32'hFFFF_4515, 32'h0050_0513, 1'b0);
    vec("lw",        32'h0000_41C8, 32'h0045_A503, 1'b0);
    vec("sd",        32'h0000_E588, 32'h00A5_B423, 1'b0);
    vec("addi16sp",  32'h0000_717D, 32'hFF01_0113, 1'b0);
    vec("lui",       32'h0000_6505, 32'h0000_1537, 1'b0);
    vec("srai",      32'h0000_850D, 32'h4035_5513, 1'b0);
    vec("sub",       32'h0000_8D0D, 32'h40B5_0533, 1'b0);
    vec("addw",      32'h0000_9D2D, 32'h00B5_053B, 1'b0);
    vec("j_neg",     32'h0000_BFFD, 32'hFFFF_F06F, 1'b0);
    vec("j_pos",     32'h0000_A021, 32'h0080_006F, 1'b0);
    vec("bnez",      32'h0000_E901, 32'h0005_1863, 1'b0);
    vec("ldsp",      32'h0000_6522, 32'h0081_3503, 1'b0);
    vec("sdsp",      32'h0000_E82A, 32'h00A1_3823, 1'b0);
    vec("addi_neg",  32'h0000_157D, 32'hFFF5_0513, 1'b0);
    vec("slli33",    32'h0000_1506, 32'h0215_1513, 1'b0);
    vec("add",       32'h0000_952E, 32'h00B5_0533, 1'b0);
    vec("jalr",      32'h0000_9502, 32'h0005_00E7, 1'b0);
    vec("hint_li",   32'h0000_4015, 32'h0050_0013, 1'b0);

    vec("ill_fld",   32'h0000_2000, 32'h0, 1'b1);
    vec("ill_addiw", 32'h0000_2001, 32'h0, 1'b1);
    vec("ill_lui0",  32'h0000_6501, 32'h0, 1'b1);
    vec("ill_q1w",   32'h0000_9C41, 32'h0, 1'b1);
    vec("ill_lwsp",  32'h0000_4002, 32'h0, 1'b1);
    vec("ill_jr0",   32'h0000_8002, 32'h0, 1'b1);
    vec("ill_q2f5",  32'h0000_A002, 32'h0, 1'b1);

    @(negedge clock);
    pc_i = 64'h8000_0010;
    vec("ill_zero",  32'h0000_0000, 32'h0, 1'b1);
    @(posedge clock);
    #1 chk("ill_pc_load", illegal_pc_o, 64'h8000_0010);

    @(negedge clock);
    pc_i = 64'h0000_1234;
    inst_i = 32'h0000_4515;
    @(posedge clock);
    #1 chk("ill_pc_hold", illegal_pc_o, 64'h8000_0010);

    #2 reset = 1'b1;
    #1 chk("ill_pc_rst", illegal_pc_o, 64'h0);
    chk("inst_in_rst", {32'b0, inst_o}, 64'h0050_0513);
    #5 reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
